// File: rtl/mastermind_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mastermind_pkg
// Purpose  : Game-wide constants and types. The guess entry, scorer and HEX
//            display stages all import this package.
// Contents : NUM_PEGS, NUM_COLOURS, COLOUR_W, MAX_GUESSES, colour_t,
//            entry_state_t
// Revision : 1.0 - initial release
// ============================================================================
package mastermind_pkg;

    localparam int NUM_PEGS    = 4;
    localparam int NUM_COLOURS = 6;
    localparam int COLOUR_W    = 3;
    localparam int MAX_GUESSES = 10;

    typedef logic [COLOUR_W-1:0] colour_t;

    typedef enum logic [1:0] {
        ENTER  = 2'd0,
        SUBMIT = 2'd1,
        DONE   = 2'd2
    } entry_state_t;

endpackage : mastermind_pkg
`default_nettype wire

// File: rtl/peg_colour_counter.sv
`default_nettype none
// ============================================================================
// Module   : peg_colour_counter
// Purpose  : Colour of one peg. This is a wrapping mod-NUM_COLOURS counter.
//            Priority is clear > hold > inc.
// Ports    : clk, Reset (async, active-high)
//            inc   - advance colour by one (NUM_COLOURS-1 wraps to 0)
//            clear - force colour 0
//            hold  - freeze the current colour
//            value - current colour
// Revision : 1.0 - initial release
// ============================================================================
module peg_colour_counter #(
    parameter int NUM_COLOURS = mastermind_pkg::NUM_COLOURS,
    parameter int COLOUR_W    = mastermind_pkg::COLOUR_W
) (
    input  logic                clk,
    input  logic                Reset,
    input  logic                inc,
    input  logic                clear,
    input  logic                hold,
    output logic [COLOUR_W-1:0] value
);
    import mastermind_pkg::*;

    localparam logic [COLOUR_W-1:0] c_last = COLOUR_W'(NUM_COLOURS - 1);

    logic [COLOUR_W-1:0] r_value;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_value <= '0;
        end else if (clear) begin
            r_value <= '0;
        end else if (!hold && inc) begin
            r_value <= (r_value == c_last) ? '0 : r_value + COLOUR_W'(1);
        end
    end

    assign value = r_value;

endmodule : peg_colour_counter
`default_nettype wire

// File: rtl/guess_entry.sv
`default_nettype none
// ============================================================================
// Module   : guess_entry
// Purpose  : Builds a Mastermind guess from the edge-detected key pulses.
//            It offers the guess to the scorer over valid/ready, counts the
//            accepted guesses and locks in DONE when the game ends.
// Ports    : clk, Reset (async, active-high)
//            incPulse/nextPulse/submitPulse/newGame - one-cycle key pulses
//            winIn       - scorer reports an exact match
//            guess       - peg p at [p*COLOUR_W +: COLOUR_W]
//            cursor      - selected peg
//            guessValid  - guess offered to the scorer
//            guessReady  - scorer takes the offered guess
//            guessCount  - number of guesses accepted
//            gameOver    - high while locked in DONE
// Revision : 1.0 - initial release
// ============================================================================
module guess_entry #(
    parameter int NUM_PEGS    = mastermind_pkg::NUM_PEGS,
    parameter int NUM_COLOURS = mastermind_pkg::NUM_COLOURS,
    parameter int COLOUR_W    = mastermind_pkg::COLOUR_W,
    parameter int MAX_GUESSES = mastermind_pkg::MAX_GUESSES,
    parameter int CNT_W       = 4
) (
    input  logic                         clk,
    input  logic                         Reset,
    input  logic                         incPulse,
    input  logic                         nextPulse,
    input  logic                         submitPulse,
    input  logic                         newGame,
    input  logic                         winIn,
    output logic [NUM_PEGS*COLOUR_W-1:0] guess,
    output logic [$clog2(NUM_PEGS)-1:0]  cursor,
    output logic                         guessValid,
    input  logic                         guessReady,
    output logic [CNT_W-1:0]             guessCount,
    output logic                         gameOver
);
    import mastermind_pkg::*;

    localparam int                CUR_W      = $clog2(NUM_PEGS);
    localparam logic [CUR_W-1:0]  c_cur_last = CUR_W'(NUM_PEGS - 1);
    // When the counter holds this value, the current transfer is the final guess.
    localparam logic [CNT_W-1:0]  c_cnt_last = CNT_W'(MAX_GUESSES - 1);

    entry_state_t       r_state;
    entry_state_t       w_state_next;
    logic [CUR_W-1:0]   r_cursor;
    logic [CNT_W-1:0]   r_count;
    logic               r_valid;
    logic               r_over;

    logic               w_clear;      // pegs and cursor back to 0
    logic               w_cnt_clear;  // guess counter back to 0
    logic               w_take;       // handshake transfer on this edge
    logic               w_cur_adv;
    logic               w_inc_req;
    logic               w_hold;

    // ------------------------------------------------------------------
    // Next-state and action decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_cnt_clear  = 1'b0;
        w_take       = 1'b0;
        w_cur_adv    = 1'b0;
        w_inc_req    = 1'b0;

        case (r_state)
            ENTER: begin
                if (newGame) begin
                    w_clear      = 1'b1;
                    w_cnt_clear  = 1'b1;
                end else if (winIn) begin
                    w_clear      = 1'b1;
                    w_state_next = DONE;
                end else if (submitPulse) begin
                    w_state_next = SUBMIT;
                end else if (nextPulse) begin
                    w_cur_adv    = 1'b1;
                end else if (incPulse) begin
                    w_inc_req    = 1'b1;
                end
            end

            SUBMIT: begin
                if (newGame) begin
                    w_clear      = 1'b1;
                    w_cnt_clear  = 1'b1;
                    w_state_next = ENTER;
                end else if (guessReady) begin
                    // A win on the same edge still counts the transfer.
                    w_take       = 1'b1;
                    w_clear      = 1'b1;
                    w_state_next = (winIn || (r_count == c_cnt_last)) ? DONE : ENTER;
                end else if (winIn) begin
                    w_clear      = 1'b1;
                    w_state_next = DONE;
                end
            end

            DONE: begin
                if (newGame) begin
                    w_clear      = 1'b1;
                    w_cnt_clear  = 1'b1;
                    w_state_next = ENTER;
                end
            end

            default: begin
                w_clear      = 1'b1;
                w_state_next = ENTER;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, cursor, counter and registered status flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state  <= ENTER;
            r_cursor <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_over   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_valid <= (w_state_next == SUBMIT);
            r_over  <= (w_state_next == DONE);

            if (w_clear) begin
                r_cursor <= '0;
            end else if (w_cur_adv) begin
                r_cursor <= (r_cursor == c_cur_last) ? '0 : r_cursor + CUR_W'(1);
            end

            if (w_cnt_clear) begin
                r_count <= '0;
            end else if (w_take) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Peg colour counters. Only the peg under the cursor advances.
    // ------------------------------------------------------------------
    assign w_hold = (r_state != ENTER);

    for (genvar p = 0; p < NUM_PEGS; p++) begin : g_peg
        peg_colour_counter #(
            .NUM_COLOURS (NUM_COLOURS),
            .COLOUR_W    (COLOUR_W)
        ) u_peg (
            .clk   (clk),
            .Reset (Reset),
            .inc   (w_inc_req && (r_cursor == CUR_W'(p))),
            .clear (w_clear),
            .hold  (w_hold),
            .value (guess[p*COLOUR_W +: COLOUR_W])
        );
    end

    assign cursor     = r_cursor;
    assign guessValid = r_valid;
    assign guessCount = r_count;
    assign gameOver   = r_over;

endmodule : guess_entry
`default_nettype wire

// File: tb/tb_guess_entry.sv
`default_nettype none
// ============================================================================
// Module   : tb_guess_entry
// Purpose  : Self-checking bench for guess_entry. A game-level reference
//            model is compared with the DUT on every falling edge. Directed
//            scenarios add fixed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_guess_entry;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic        incPulse = 1'b0, nextPulse = 1'b0, submitPulse = 1'b0;
    logic        newGame = 1'b0, winIn = 1'b0, guessReady = 1'b0;
    logic [11:0] guess;
    logic [1:0]  cursor;
    logic        guessValid;
    logic [3:0]  guessCount;
    logic        gameOver;

    int total = 0;
    int bad   = 0;

    guess_entry dut (
        .clk         (clk),
        .Reset       (Reset),
        .incPulse    (incPulse),
        .nextPulse   (nextPulse),
        .submitPulse (submitPulse),
        .newGame     (newGame),
        .winIn       (winIn),
        .guess       (guess),
        .cursor      (cursor),
        .guessValid  (guessValid),
        .guessReady  (guessReady),
        .guessCount  (guessCount),
        .gameOver    (gameOver)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (game rules) ----------------
    // phase: 0 = entering, 1 = offering guess, 2 = game finished
    int m_peg [4] = '{0, 0, 0, 0};
    int m_cur   = 0;
    int m_cnt   = 0;
    int m_phase = 0;

    function automatic void m_wipe();
        for (int i = 0; i < 4; i++) m_peg[i] = 0;
        m_cur = 0;
    endfunction

    always @(posedge clk or posedge Reset) begin
        if (Reset) begin
            m_wipe();
            m_cnt   = 0;
            m_phase = 0;
        end else if (newGame) begin
            m_wipe();
            m_cnt   = 0;
            m_phase = 0;
        end else if (m_phase == 1) begin
            if (guessReady) begin
                m_cnt   = m_cnt + 1;
                m_wipe();
                m_phase = (winIn || m_cnt == 10) ? 2 : 0;
            end else if (winIn) begin
                m_wipe();
                m_phase = 2;
            end
        end else if (m_phase == 0) begin
            if (winIn) begin
                m_wipe();
                m_phase = 2;
            end else if (submitPulse) m_phase = 1;
            else if (nextPulse)       m_cur = (m_cur + 1) % 4;
            else if (incPulse)        m_peg[m_cur] = (m_peg[m_cur] + 1) % 6;
        end
    end

    function automatic int m_guess();
        int g = 0;
        for (int i = 0; i < 4; i++) g += m_peg[i] * (1 << (3 * i));
        return g;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!Reset) begin
            chk("model.guess",  int'(guess),      m_guess());
            chk("model.cursor", int'(cursor),     m_cur);
            chk("model.valid",  int'(guessValid), (m_phase == 1) ? 1 : 0);
            chk("model.count",  int'(guessCount), m_cnt);
            chk("model.over",   int'(gameOver),   (m_phase == 2) ? 1 : 0);
        end
    end

    // One cycle of stimulus, applied just after a rising edge. All inputs
    // drop afterwards, so the caller is left just after the next edge.
    task automatic cyc(input logic ng, input logic win, input logic sub,
                       input logic nxt, input logic inc, input logic rdy);
        newGame = ng; winIn = win; submitPulse = sub;
        nextPulse = nxt; incPulse = inc; guessReady = rdy;
        @(posedge clk);
        #1;
        newGame = 0; winIn = 0; submitPulse = 0;
        nextPulse = 0; incPulse = 0; guessReady = 0;
    endtask

    task automatic incs(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 1, 0);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        repeat (2) @(posedge clk);
        #1 Reset = 0;
        chk("rst.guess", int'(guess), 0);
        chk("rst.valid", int'(guessValid), 0);

        // 1. asynchronous reset in the middle of a cycle
        incs(3);
        cyc(0, 0, 0, 1, 0, 0);
        #3 Reset = 1;
        #1;
        chk("async.guess",  int'(guess),      0);
        chk("async.cursor", int'(cursor),     0);
        chk("async.valid",  int'(guessValid), 0);
        chk("async.count",  int'(guessCount), 0);
        @(posedge clk);
        #1 Reset = 0;

        // 2. colour wrap and cursor wrap
        incs(7);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0, 0);
        chk("wrap.guess",  int'(guess),  'h001);
        chk("wrap.cursor", int'(cursor), 1);

        // 3. build 2,4,1,5 and stall the handshake
        incs(4); cyc(0, 0, 0, 1, 0, 0);
        incs(1); cyc(0, 0, 0, 1, 0, 0);
        incs(5); cyc(0, 0, 0, 1, 0, 0);
        incs(1);
        chk("build.guess", int'(guess), 'hA62);
        cyc(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, 1, 0);
            chk("stall.valid", int'(guessValid), 1);
            chk("stall.guess", int'(guess), 'hA62);
        end
        cyc(0, 0, 0, 0, 0, 1);
        chk("xfer.valid", int'(guessValid), 0);
        chk("xfer.guess", int'(guess),      0);
        chk("xfer.count", int'(guessCount), 1);

        // ready without an offer does nothing
        cyc(0, 0, 0, 0, 0, 1);
        chk("idle_rdy.count", int'(guessCount), 1);

        // 4. simultaneous pulses: submit wins
        incs(2);
        cyc(0, 0, 1, 1, 1, 0);
        chk("prio.guess",  int'(guess),      'h002);
        chk("prio.cursor", int'(cursor),     0);
        chk("prio.valid",  int'(guessValid), 1);
        cyc(0, 0, 0, 0, 0, 1);

        // 5. ten guesses lock the game
        cyc(1, 0, 0, 0, 0, 0);
        chk("ng.count", int'(guessCount), 0);
        for (int g = 0; g < 10; g++) begin
            incs(g % 3);
            cyc(0, 0, 1, 0, 0, 0);
            cyc(0, 0, 0, 0, 0, 1);
        end
        chk("max.over",  int'(gameOver),   1);
        chk("max.count", int'(guessCount), 10);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0, 1);
        chk("lock.guess", int'(guess),      0);
        chk("lock.valid", int'(guessValid), 0);
        chk("lock.over",  int'(gameOver),   1);
        cyc(1, 0, 0, 0, 0, 0);
        chk("reopen.over",  int'(gameOver),   0);
        chk("reopen.count", int'(guessCount), 0);

        // 6. win during a stalled offer, then win coincident with transfer
        incs(1);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("win.over",  int'(gameOver),   1);
        chk("win.valid", int'(guessValid), 0);
        chk("win.count", int'(guessCount), 0);
        cyc(1, 0, 0, 0, 0, 0);
        incs(2);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 1);
        chk("winx.over",  int'(gameOver),   1);
        chk("winx.count", int'(guessCount), 1);
        chk("winx.guess", int'(guess),      0);

        // newGame aborting an offer
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("abort.valid", int'(guessValid), 0);
        chk("abort.count", int'(guessCount), 0);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_guess_entry
`default_nettype wire
